// File: rtl/sram_read_arbiter_pkg.sv
// Shared types and constants for the SRAM read-channel arbiter and its picker.
package sram_read_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        AR_IFU = 3'd1,
        R_IFU  = 3'd2,
        AR_LSU = 3'd3,
        R_LSU  = 3'd4
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_IFU  = 2'b01;
    localparam logic [1:0] GRANT_LSU  = 2'b10;

    // Encoding of the last_owner bit used by the round-robin tie-break.
    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/sram_read_arbiter_pick2.sv
// Combinational two-request picker; with RR_EN a tie goes to the master that is
// not last_owner, otherwise the LSU always wins a tie.
module arb_pick2
    import sram_read_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic req_ifu,
    input  logic req_lsu,
    input  logic last_owner,
    output logic pick_ifu,
    output logic pick_lsu
);

    logic tie_to_lsu;

    always_comb begin
        tie_to_lsu = RR_EN ? (last_owner == OWNER_IFU) : 1'b1;
        pick_lsu   = req_lsu & (~req_ifu | tie_to_lsu);
        pick_ifu   = req_ifu & (~req_lsu | ~tie_to_lsu);
    end

endmodule

// File: rtl/sram_read_arbiter.sv
// IFU/LSU arbiter for the SRAM AR/R channels, one outstanding read at a time.
// Define ARB_RR_EN for round-robin tie-break; default build is fixed LSU priority.
module sram_read_arbiter
    import sram_read_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [ADDR_W-1:0] sram_araddr,
    output logic              sram_arvalid,
    input  logic              sram_arready,
    input  logic              sram_rvalid,
    output logic              sram_rready,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [1:0]        grant
);

    state_t state;
    logic   pick_ifu;
    logic   pick_lsu;
    logic   last_owner;

`ifdef ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
    assign last_owner = OWNER_IFU;
`endif

    arb_pick2 #(.RR_EN(RR_EN)) u_pick (
        .req_ifu    (ifu_arvalid),
        .req_lsu    (lsu_arvalid),
        .last_owner (last_owner),
        .pick_ifu   (pick_ifu),
        .pick_lsu   (pick_lsu)
    );

    // Arbitration happens only in IDLE, so every grant costs one bubble cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
`ifdef ARB_RR_EN
            last_owner <= OWNER_IFU;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_lsu) begin
                        state <= AR_LSU;
`ifdef ARB_RR_EN
                        last_owner <= OWNER_LSU;
`endif
                    end else if (pick_ifu) begin
                        state <= AR_IFU;
`ifdef ARB_RR_EN
                        last_owner <= OWNER_IFU;
`endif
                    end
                end
                AR_IFU: begin
                    if (!ifu_arvalid)       state <= IDLE;
                    else if (sram_arready)  state <= R_IFU;
                end
                R_IFU: begin
                    if (sram_rvalid && ifu_rready) state <= IDLE;
                end
                AR_LSU: begin
                    if (!lsu_arvalid)       state <= IDLE;
                    else if (sram_arready)  state <= R_LSU;
                end
                R_LSU: begin
                    if (sram_rvalid && lsu_rready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Valid/ready semantics: a beat transfers on the cycle where valid and ready
    // are both high; the arbiter only routes, it never buffers a beat.
    always_comb begin
        ifu_arready  = 1'b0;
        ifu_rvalid   = 1'b0;
        ifu_rdata    = '0;
        lsu_arready  = 1'b0;
        lsu_rvalid   = 1'b0;
        lsu_rdata    = '0;
        sram_araddr  = '0;
        sram_arvalid = 1'b0;
        sram_rready  = 1'b0;
        grant        = GRANT_NONE;
        case (state)
            AR_IFU: begin
                grant        = GRANT_IFU;
                sram_araddr  = ifu_araddr;
                sram_arvalid = ifu_arvalid;
                ifu_arready  = sram_arready;
            end
            R_IFU: begin
                grant       = GRANT_IFU;
                ifu_rvalid  = sram_rvalid;
                ifu_rdata   = sram_rdata;
                sram_rready = ifu_rready;
            end
            AR_LSU: begin
                grant        = GRANT_LSU;
                sram_araddr  = lsu_araddr;
                sram_arvalid = lsu_arvalid;
                lsu_arready  = sram_arready;
            end
            R_LSU: begin
                grant       = GRANT_LSU;
                lsu_rvalid  = sram_rvalid;
                lsu_rdata   = sram_rdata;
                sram_rready = lsu_rready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Directed, table-driven bench for sram_read_arbiter: one row per clock cycle
// holding the inputs for that cycle and the hand-derived outputs.
module tb_sram_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr, lsu_araddr, sram_araddr, sram_rdata;
    logic [31:0] ifu_rdata, lsu_rdata;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic        sram_arvalid, sram_arready, sram_rvalid, sram_rready;
    logic [1:0]  grant;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    sram_read_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .ifu_araddr   (ifu_araddr),
        .ifu_arvalid  (ifu_arvalid),
        .ifu_arready  (ifu_arready),
        .ifu_rvalid   (ifu_rvalid),
        .ifu_rready   (ifu_rready),
        .ifu_rdata    (ifu_rdata),
        .lsu_araddr   (lsu_araddr),
        .lsu_arvalid  (lsu_arvalid),
        .lsu_arready  (lsu_arready),
        .lsu_rvalid   (lsu_rvalid),
        .lsu_rready   (lsu_rready),
        .lsu_rdata    (lsu_rdata),
        .sram_araddr  (sram_araddr),
        .sram_arvalid (sram_arvalid),
        .sram_arready (sram_arready),
        .sram_rvalid  (sram_rvalid),
        .sram_rready  (sram_rready),
        .sram_rdata   (sram_rdata),
        .grant        (grant)
    );

    // in_b = {ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready, sram_arready, sram_rvalid}
    // ex_b = {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, sram_arvalid, sram_rready}
    typedef struct {
        logic [5:0]  in_b;
        logic [31:0] rd;
        logic [1:0]  g;
        logic [5:0]  ex_b;
        logic [31:0] s_addr;
        logic [31:0] i_rd;
        logic [31:0] l_rd;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] JUNK = 32'hA5A5_A5A5;
    localparam logic [31:0] D    = 32'hDEAD_BEEF;
    localparam logic [31:0] R1   = 32'h1111_2222;
    localparam logic [31:0] R2   = 32'h3333_4444;

    function automatic vec_t mk(logic [5:0] in_b, logic [31:0] rd, logic [1:0] g,
                                logic [5:0] ex_b, logic [31:0] s_addr,
                                logic [31:0] i_rd, logic [31:0] l_rd);
        vec_t v;
        v.in_b = in_b; v.rd = rd; v.g = g; v.ex_b = ex_b;
        v.s_addr = s_addr; v.i_rd = i_rd; v.l_rd = l_rd;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, ".grant"},        32'(grant),        32'd0);
        chk({tag, ".ifu_arready"},  32'(ifu_arready),  32'd0);
        chk({tag, ".ifu_rvalid"},   32'(ifu_rvalid),   32'd0);
        chk({tag, ".ifu_rdata"},    ifu_rdata,         32'd0);
        chk({tag, ".lsu_arready"},  32'(lsu_arready),  32'd0);
        chk({tag, ".lsu_rvalid"},   32'(lsu_rvalid),   32'd0);
        chk({tag, ".lsu_rdata"},    lsu_rdata,         32'd0);
        chk({tag, ".sram_araddr"},  sram_araddr,       32'd0);
        chk({tag, ".sram_arvalid"}, 32'(sram_arvalid), 32'd0);
        chk({tag, ".sram_rready"},  32'(sram_rready),  32'd0);
    endtask

    task automatic drive_row(vec_t v);
        {ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready, sram_arready, sram_rvalid} = v.in_b;
        sram_rdata = v.rd;
    endtask

    task automatic check_row(vec_t v, string tag);
        chk({tag, ".grant"},        32'(grant),        32'(v.g));
        chk({tag, ".ifu_arready"},  32'(ifu_arready),  32'(v.ex_b[5]));
        chk({tag, ".ifu_rvalid"},   32'(ifu_rvalid),   32'(v.ex_b[4]));
        chk({tag, ".lsu_arready"},  32'(lsu_arready),  32'(v.ex_b[3]));
        chk({tag, ".lsu_rvalid"},   32'(lsu_rvalid),   32'(v.ex_b[2]));
        chk({tag, ".sram_arvalid"}, 32'(sram_arvalid), 32'(v.ex_b[1]));
        chk({tag, ".sram_rready"},  32'(sram_rready),  32'(v.ex_b[0]));
        chk({tag, ".sram_araddr"},  sram_araddr,       v.s_addr);
        chk({tag, ".ifu_rdata"},    ifu_rdata,         v.i_rd);
        chk({tag, ".lsu_rdata"},    lsu_rdata,         v.l_rd);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic run_table(string name);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive_row(tbl[i]);
            #1;
            check_row(tbl[i], $sformatf("%s[%0d]", name, i));
        end
        tbl.delete();
    endtask

    initial begin
        rst = 1'b0;
        ifu_araddr = '0; lsu_araddr = '0; sram_rdata = '0;
        ifu_arvalid = 0; ifu_rready = 0; lsu_arvalid = 0; lsu_rready = 0;
        sram_arready = 0; sram_rvalid = 0;

        // Reset held with random inputs: everything must stay at 0.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ifu_araddr = $urandom; lsu_araddr = $urandom; sram_rdata = $urandom;
            {ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready, sram_arready, sram_rvalid} =
                6'($urandom_range(0, 63));
            #1;
            chk_all_zero($sformatf("reset[%0d]", i));
        end
        @(negedge clk);
        {ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready, sram_arready, sram_rvalid} = '0;
        rst = 1'b1;
        tbl.push_back(mk(6'b000000, JUNK, 2'b00, 6'b000000, 0, 0, 0));
        tbl.push_back(mk(6'b000000, JUNK, 2'b00, 6'b000000, 0, 0, 0));
        run_table("idle");

        // Single IFU read: arready after 2 AR cycles, rvalid after 3, rready one late.
        ifu_araddr = 32'h8000_0000; lsu_araddr = 32'h0BAD_0000;
        tbl.push_back(mk(6'b100000, D, 2'b00, 6'b000000, 0, 0, 0));
        tbl.push_back(mk(6'b100000, D, 2'b01, 6'b000010, 32'h8000_0000, 0, 0));
        tbl.push_back(mk(6'b100000, D, 2'b01, 6'b000010, 32'h8000_0000, 0, 0));
        tbl.push_back(mk(6'b100010, D, 2'b01, 6'b100010, 32'h8000_0000, 0, 0));
        tbl.push_back(mk(6'b000000, D, 2'b01, 6'b000000, 0, D, 0));
        tbl.push_back(mk(6'b000000, D, 2'b01, 6'b000000, 0, D, 0));
        tbl.push_back(mk(6'b000001, D, 2'b01, 6'b010000, 0, D, 0));
        tbl.push_back(mk(6'b010001, D, 2'b01, 6'b010001, 0, D, 0));
        tbl.push_back(mk(6'b000000, D, 2'b00, 6'b000000, 0, 0, 0));
        run_table("ifu_read");

        // Two back-to-back ties.
        ifu_araddr = 32'h8000_0004; lsu_araddr = 32'h8000_1000;
        tbl.push_back(mk(6'b101000, JUNK, 2'b00, 6'b000000, 0, 0, 0));
        tbl.push_back(mk(6'b101010, JUNK, 2'b10, 6'b001010, 32'h8000_1000, 0, 0));
        tbl.push_back(mk(6'b100101, R1,   2'b10, 6'b000101, 0, 0, R1));
        tbl.push_back(mk(6'b101000, JUNK, 2'b00, 6'b000000, 0, 0, 0));
`ifdef ARB_RR_EN
        tbl.push_back(mk(6'b101010, JUNK, 2'b01, 6'b100010, 32'h8000_0004, 0, 0));
        tbl.push_back(mk(6'b011001, R2,   2'b01, 6'b010001, 0, R2, 0));
        tbl.push_back(mk(6'b001000, JUNK, 2'b00, 6'b000000, 0, 0, 0));
        tbl.push_back(mk(6'b001010, JUNK, 2'b10, 6'b001010, 32'h8000_1000, 0, 0));
        tbl.push_back(mk(6'b000101, R1,   2'b10, 6'b000101, 0, 0, R1));
`else
        tbl.push_back(mk(6'b101010, JUNK, 2'b10, 6'b001010, 32'h8000_1000, 0, 0));
        tbl.push_back(mk(6'b100101, R2,   2'b10, 6'b000101, 0, 0, R2));
        tbl.push_back(mk(6'b100000, JUNK, 2'b00, 6'b000000, 0, 0, 0));
        tbl.push_back(mk(6'b100010, JUNK, 2'b01, 6'b100010, 32'h8000_0004, 0, 0));
        tbl.push_back(mk(6'b010001, R1,   2'b01, 6'b010001, 0, R1, 0));
`endif
        tbl.push_back(mk(6'b000000, JUNK, 2'b00, 6'b000000, 0, 0, 0));
        run_table("tie");

        // LSU arrives while the IFU response is pending.
        ifu_araddr = 32'h8000_0000; lsu_araddr = 32'h8000_1000;
        tbl.push_back(mk(6'b100000, D, 2'b00, 6'b000000, 0, 0, 0));
        tbl.push_back(mk(6'b100010, D, 2'b01, 6'b100010, 32'h8000_0000, 0, 0));
        tbl.push_back(mk(6'b001000, D, 2'b01, 6'b000000, 0, D, 0));
        tbl.push_back(mk(6'b011001, D, 2'b01, 6'b010001, 0, D, 0));
        tbl.push_back(mk(6'b001000, D, 2'b00, 6'b000000, 0, 0, 0));
        tbl.push_back(mk(6'b001000, D, 2'b10, 6'b000010, 32'h8000_1000, 0, 0));
        tbl.push_back(mk(6'b001010, D, 2'b10, 6'b001010, 32'h8000_1000, 0, 0));
        tbl.push_back(mk(6'b000101, D, 2'b10, 6'b000101, 0, 0, D));
        tbl.push_back(mk(6'b000000, D, 2'b00, 6'b000000, 0, 0, 0));
        run_table("late");

        // IFU withdraws arvalid before the SRAM accepts: back to IDLE.
        tbl.push_back(mk(6'b100000, JUNK, 2'b00, 6'b000000, 0, 0, 0));
        tbl.push_back(mk(6'b100000, JUNK, 2'b01, 6'b000010, 32'h8000_0000, 0, 0));
        tbl.push_back(mk(6'b000000, JUNK, 2'b01, 6'b000000, 32'h8000_0000, 0, 0));
        tbl.push_back(mk(6'b000000, JUNK, 2'b00, 6'b000000, 0, 0, 0));
        tbl.push_back(mk(6'b000000, JUNK, 2'b00, 6'b000000, 0, 0, 0));
        run_table("abort");

        // Reset asserted in R_LSU with sram_rvalid high.
        tbl.push_back(mk(6'b001000, D, 2'b00, 6'b000000, 0, 0, 0));
        tbl.push_back(mk(6'b001010, D, 2'b10, 6'b001010, 32'h8000_1000, 0, 0));
        tbl.push_back(mk(6'b000001, D, 2'b10, 6'b000100, 0, 0, D));
        run_table("mid_rst");
        #2 rst = 1'b0;
        #1;
        chk("mid_rst.async.lsu_rvalid", 32'(lsu_rvalid), 32'd0);
        chk("mid_rst.async.lsu_rdata",  lsu_rdata,       32'd0);
        chk("mid_rst.async.grant",      32'(grant),      32'd0);
        chk("mid_rst.async.sram_rready", 32'(sram_rready), 32'd0);
        @(negedge clk);
        sram_rvalid = 1'b0;
        rst = 1'b1;
        tbl.push_back(mk(6'b000000, D, 2'b00, 6'b000000, 0, 0, 0));
        tbl.push_back(mk(6'b000001, D, 2'b00, 6'b000000, 0, 0, 0));
        run_table("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
